top_level: RTL and testbench
============================

# top_level

Hardwired program-1 engine for the course processor's top level. On release from reset it SECDED-encodes 15 11-bit messages held in its internal byte-wide data memory into 16-bit Hamming words. It writes the results back to that memory, then raises `done`. The memory is preloaded and inspected hierarchically by the bench, so its instance and array names are part of the interface.

## Interface
- `progID`, default 1: program selector; only 1 is implemented.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears control state, never memory.
- `done`  out  1  high when the program has finished; held until next reset.
- Hierarchical: `dm1.core[0:255]`, 8 bits per entry, must exist with exactly these names.

## Operation
- Input message i (i = 0..14):
  - `core[2i]` = d[8:1].
  - `core[2i+1][2:0]` = d[11:9]; bits [7:3] are ignored.
- Parity, with ^ denoting XOR-reduce:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1
- Output word W = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
  - `core[30+2i]` = W[7:0].
  - `core[31+2i]` = W[15:8].
- Bytes 0..29 are never written; bytes 60..255 are untouched.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE → RD_LO on the first clock after reset release.
  - RD_LO → RD_HI → WR_LO → WR_HI.
  - WR_HI → RD_LO with i+1 while i<14; at i==14, WR_HI → DONE.
  - DONE is absorbing.
- Memory: combinational read, synchronous write, single write port, 8-bit address.
- Encoding is purely combinational from the latched lo/hi bytes.
- progID ≠ 1: FSM goes IDLE → DONE directly; no memory writes.

## Timing
- While `reset` = 0: FSM = IDLE, i = 0, `done` = 0, latches = 0; memory retained.
- Per message: 4 cycles, so the program takes 60 cycles.
- `done` rises on the 61st rising edge after reset deassertion (registered; asserted on the edge that enters DONE).
- Each write commits on the rising edge that ends the WR_* state.
- Reset asserted mid-run:
  - Stops immediately; partial outputs remain in memory.
  - Next release restarts from message 0 and overwrites all outputs (idempotent, since inputs are untouched).
- Memory may be loaded hierarchically while in reset or while in DONE.

## Configuration
- `PROG1_TRACE_EN` defined: on each WR_HI, simulation-only `$display` of i, d (binary) and W (binary).
- Macro absent: no display code at all.
- Cycle behaviour and memory contents are identical in both cases.

## Structure
- Package `prog1_pkg` holds:
  - Constants NUM_MSGS=15, IN_BASE=0, OUT_BASE=30, MEM_DEPTH=256.
  - `state_t` enum.
  - Function `hamming_encode(logic [11:1] d)` returning `logic [15:0]`.
- Sub-module `data_mem`, instantiated as `dm1`:
  - Array `core` of 256 × 8 bits.
  - Ports: `clk`, `wr_en`, `addr[7:0]`, `wr_data[7:0]`, `rd_data[7:0]`.
  - No reset.

## Test plan
- All 15 messages = 0x000 → every output byte in 30..59 = 0x00; `done` at cycle 61.
- Message 0 = 0x7FF (`core[1]`=0x07, `core[0]`=0xFF) → `core[31]`=0xFF, `core[30]`=0xFF.
- Message 3 = 0x001 → `core[37]`=0x00, `core[36]`=0x0F.
- Message 14 = 0x400 (`core[29]`=0xFC, whose upper bits must be ignored; `core[28]`=0x00) → `core[59]`=0x81, `core[58]`=0x17.
- 15 random messages → all 15 words match the golden encode; bytes 0..29 unchanged; `done` stays high.
- Reset pulsed low at cycle 20, then released → `done` low during reset; rises 61 cycles after release; all outputs correct.

Source files
------------

// File: rtl/prog1_pkg.sv
// Shared constants, FSM state type and the SECDED encoder for the program-1 engine.
package prog1_pkg;

    localparam int         NUM_MSGS  = 15;
    localparam logic [7:0] IN_BASE   = 8'd0;
    localparam logic [7:0] OUT_BASE  = 8'd30;
    localparam int         MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Bit i of d is data bit di; W places parity at positions 8,4,2,1 and overall parity at 0.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous single-port write, no reset.
module data_mem
    import prog1_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data
);

    logic [7:0] core [0:MEM_DEPTH-1];

    assign rd_data = core[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            core[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/top_level.sv
// Program-1 engine: SECDED-encodes 15 messages from dm1 bytes 0..29 into bytes 30..59.
// Define PROG1_TRACE_EN to print each encoded word in simulation.
module top_level
    import prog1_pkg::*;
#(
    parameter int progID = 1
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       done_q, done_d;

    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] pair_off;
    logic [15:0] word;

    data_mem dm1 (
        .clk     (clk),
        .wr_en   (mem_we),
        .addr    (mem_addr),
        .wr_data (mem_wdata),
        .rd_data (mem_rdata)
    );

    assign pair_off = {3'b000, idx_q, 1'b0};
    // Only bits [2:0] of the high input byte carry data.
    assign word     = hamming_encode({hi_q[2:0], lo_q});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        mem_we    = 1'b0;
        mem_addr  = IN_BASE + pair_off;
        mem_wdata = 8'h00;
        case (state_q)
            IDLE: begin
                idx_d   = 4'd0;
                state_d = (progID == 1) ? RD_LO : DONE;
            end
            RD_LO: begin
                mem_addr = IN_BASE + pair_off;
                lo_d     = mem_rdata;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = IN_BASE + pair_off + 8'd1;
                hi_d     = mem_rdata;
                state_d  = WR_LO;
            end
            WR_LO: begin
                mem_addr  = OUT_BASE + pair_off;
                mem_we    = 1'b1;
                mem_wdata = word[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_addr  = OUT_BASE + pair_off + 8'd1;
                mem_we    = 1'b1;
                mem_wdata = word[15:8];
                if (idx_q == 4'(NUM_MSGS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = RD_LO;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

`ifdef PROG1_TRACE_EN
    always @(posedge clk) begin
        if (reset && state_q == WR_HI) begin
            $display("prog1 msg %0d d=%b W=%b", idx_q, {hi_q[2:0], lo_q}, word);
        end
    end
`else
`endif

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: preloads dm1 hierarchically, runs the program and compares against a Hamming model.
module tb_top_level;
  import prog1_pkg::*;

  logic clk;
  logic reset;
  logic done;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] msg [15];
  logic [4:0]  junk [15];
  logic [7:0]  in_img [30];
  logic [7:0]  tail_img [256];
  logic [7:0]  exp_q [$];

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: classic SECDED layout, data in non-power-of-two positions 3..15,
  // parity at 2^k covers positions with bit k set, bit 0 is overall parity.
  function automatic logic [15:0] golden(input logic [10:0] m);
    logic [15:0] w;
    int j;
    logic par;
    w = '0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = m[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if ((p & (1 << k)) != 0) par = par ^ w[p];
      end
      w[1 << k] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  // driver tasks
  task automatic enter_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_done_in_reset"}, 16'(done), 16'd0);
  endtask

  task automatic load_mem();
    for (int i = 0; i < 15; i++) begin
      dut.dm1.core[2*i]   = msg[i][7:0];
      dut.dm1.core[2*i+1] = {junk[i], msg[i][10:8]};
      in_img[2*i]   = msg[i][7:0];
      in_img[2*i+1] = {junk[i], msg[i][10:8]};
    end
    for (int k = 30; k < 60; k++) dut.dm1.core[k] = 8'hA5;
    for (int k = 60; k < 256; k++) begin
      tail_img[k] = 8'($urandom_range(0, 255));
      dut.dm1.core[k] = tail_img[k];
    end
  endtask

  task automatic random_msgs();
    for (int i = 0; i < 15; i++) begin
      msg[i]  = 11'($urandom_range(0, 2047));
      junk[i] = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic release_and_wait(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_cycle"}, 16'(n), 16'd61);
  endtask

  // scoreboard
  task automatic check_outputs(input string tag);
    logic [15:0] w;
    for (int i = 0; i < 15; i++) begin
      w = golden(msg[i]);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
    for (int k = 30; k < 60; k++) begin
      check($sformatf("%s_out%0d", tag, k), 16'(dut.dm1.core[k]), 16'(exp_q.pop_front()));
    end
    for (int k = 0; k < 30; k++) begin
      check($sformatf("%s_in%0d", tag, k), 16'(dut.dm1.core[k]), 16'(in_img[k]));
    end
    for (int k = 60; k < 256; k++) begin
      check($sformatf("%s_tail%0d", tag, k), 16'(dut.dm1.core[k]), 16'(tail_img[k]));
    end
  endtask

  initial begin
    reset = 1'b0;
    #1;
    check("reset_done", 16'(done), 16'd0);
    check("reset_state", 16'(dut.state_q), 16'(IDLE));

    // All-zero messages
    enter_reset("zero");
    for (int i = 0; i < 15; i++) begin
      msg[i] = 11'h000;
      junk[i] = 5'd0;
    end
    load_mem();
    release_and_wait("zero");
    check_outputs("zero");

    // Directed corner values, rest random
    enter_reset("dir");
    random_msgs();
    msg[0] = 11'h7FF; junk[0] = 5'd0;
    msg[3] = 11'h001; junk[3] = 5'd0;
    msg[14] = 11'h400; junk[14] = 5'b11111;
    load_mem();
    check("dir_core29_preload", 16'(dut.dm1.core[29]), 16'h00FC);
    release_and_wait("dir");
    check("dir_core31", 16'(dut.dm1.core[31]), 16'h00FF);
    check("dir_core30", 16'(dut.dm1.core[30]), 16'h00FF);
    check("dir_core37", 16'(dut.dm1.core[37]), 16'h0000);
    check("dir_core36", 16'(dut.dm1.core[36]), 16'h000F);
    check("dir_core59", 16'(dut.dm1.core[59]), 16'h0081);
    check("dir_core58", 16'(dut.dm1.core[58]), 16'h0017);
    check_outputs("dir");

    // Fully random, done must hold
    enter_reset("rnd");
    random_msgs();
    load_mem();
    release_and_wait("rnd");
    repeat (7) @(posedge clk);
    #1;
    check("rnd_done_hold", 16'(done), 16'd1);
    check_outputs("rnd");

    // Reset pulsed mid-run, then full rerun
    enter_reset("mid");
    random_msgs();
    load_mem();
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_done_low", 16'(done), 16'd0);
    check("mid_state_idle", 16'(dut.state_q), 16'(IDLE));
    repeat (3) @(negedge clk);
    check("mid_done_still_low", 16'(done), 16'd0);
    release_and_wait("mid");
    check_outputs("mid");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
